// File: rtl/order_scheduler.sv
// ---------------------------------------------------------------------------
// order_scheduler: round-robin order intake, matching-engine handshake, trade FIFO
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module order_scheduler #(
  parameter int N_REQ      = 4,
  parameter int ENGINE_LAT = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_side,
  input  logic [8*N_REQ-1:0]   req_price,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           buy_price,
  output logic [7:0]           sell_price,
  input  logic                 match_flag,
  input  logic [7:0]           trade_price,
  output logic                 trade_valid,
  output logic [10:0]          trade_data,
  input  logic                 trade_ready,
  output logic [15:0]          trade_count,
  output logic                 overflow
);

  localparam int CW = (ENGINE_LAT < 1) ? 1 : $clog2(ENGINE_LAT + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]    state;
  logic [2:0]    last_grant;
  logic [2:0]    src_id;
  logic [CW-1:0] wait_cnt;

  // Inputs padded to the maximum requester count so a 3-bit index is always in range
  logic [7:0]    valid_pad;
  logic [7:0]    side_pad;
  logic [63:0]   price_pad;
  logic [7:0]    onehot;
  logic [3:0]    cand;
  logic [2:0]    grant_idx;
  logic          grant_any;
  logic          xfer;
  logic [7:0]    grant_price;

  assign valid_pad   = 8'(req_valid);
  assign side_pad    = 8'(req_side);
  assign price_pad   = 64'(req_price);
  assign grant_price = price_pad[{grant_idx, 3'b000} +: 8];

  always_comb begin
    grant_idx = 3'd0;
    grant_any = 1'b0;
    cand      = 4'd0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_grant} + 4'(k);
      if (cand >= 4'(N_REQ)) begin
        cand = cand - 4'(N_REQ);
      end
      if (!grant_any && valid_pad[cand[2:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[2:0];
      end
    end
  end

  assign onehot    = 8'd1 << grant_idx;
  assign req_ready = (state == IDLE && !reset && grant_any) ? onehot[N_REQ-1:0] : '0;
  assign xfer      = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      buy_price  <= 8'd0;
      sell_price <= 8'hFF;
      last_grant <= 3'(N_REQ - 1);
      src_id     <= 3'd0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            if (side_pad[grant_idx]) begin
              sell_price <= grant_price;
            end else begin
              buy_price  <= grant_price;
            end
            last_grant <= grant_idx;
            src_id     <= grant_idx;
            wait_cnt   <= CW'(ENGINE_LAT);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt <= CW'(1)) begin
            state <= CHECK;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        CHECK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  logic [10:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fill;
  logic          push;
  logic          pop;
  logic          full;
  logic          do_write;

  assign push        = (state == CHECK) && match_flag;
  assign trade_valid = (fill != '0);
  assign pop         = trade_valid && trade_ready;
  assign full        = (fill == (AW+1)'(FIFO_DEPTH));
  // When full, a same-cycle pop frees the head slot, which is the slot being written
  assign do_write    = push && (!full || pop);
  assign trade_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_write && !reset) begin
      mem[wr_ptr] <= {src_id, trade_price};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      trade_count <= 16'd0;
      overflow    <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_write, pop})
        2'b10:   fill <= fill + (AW+1)'(1);
        2'b01:   fill <= fill - (AW+1)'(1);
        default: fill <= fill;
      endcase
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
      if (push && trade_count != 16'hFFFF) begin
        trade_count <= trade_count + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire
